// File: rtl/reg_bus_arbiter.sv
// Two-master arbiter in front of the single register_file port (m0 = I2C slave, m1 = SPI slave).
// Define REG_ARB_RR_EN for round-robin arbitration; otherwise m0 has fixed priority.
module reg_bus_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_drop,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_drop,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy
);

  localparam int CNT_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_r;
  logic               grant_r;
  logic               cur_we_r;
  logic [CNT_W-1:0]   cnt_r;
`ifdef REG_ARB_RR_EN
  logic               last_grant_r;
`endif

  logic               m0_pend_r;
  logic               m0_we_r;
  logic [ADDR_W-1:0]  m0_addr_r;
  logic [DATA_W-1:0]  m0_wdata_r;
  logic               m1_pend_r;
  logic               m1_we_r;
  logic [ADDR_W-1:0]  m1_addr_r;
  logic [DATA_W-1:0]  m1_wdata_r;

  logic               m0_load_s;
  logic               m1_load_s;
  logic               win_s;

  // A request is taken when the buffer is free or is being released by this cycle's ack.
  assign m0_load_s = m0_req & (~m0_pend_r | m0_ack);
  assign m1_load_s = m1_req & (~m1_pend_r | m1_ack);

  // Winner selection among pending masters.
  always_comb begin
    win_s = 1'b0;
    if (m0_pend_r && m1_pend_r) begin
`ifdef REG_ARB_RR_EN
      win_s = ~last_grant_r;
`else
      win_s = 1'b0;
`endif
    end else if (m1_pend_r) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Request buffers, pending flags and drop pulses; load wins over the ack-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_pend_r  <= 1'b0;
      m0_we_r    <= 1'b0;
      m0_addr_r  <= '0;
      m0_wdata_r <= '0;
      m0_drop    <= 1'b0;
      m1_pend_r  <= 1'b0;
      m1_we_r    <= 1'b0;
      m1_addr_r  <= '0;
      m1_wdata_r <= '0;
      m1_drop    <= 1'b0;
    end else begin
      m0_drop <= m0_req & m0_pend_r & ~m0_ack;
      m1_drop <= m1_req & m1_pend_r & ~m1_ack;

      if (m0_load_s) begin
        m0_pend_r  <= 1'b1;
        m0_we_r    <= m0_we;
        m0_addr_r  <= m0_addr;
        m0_wdata_r <= m0_wdata;
      end else if (m0_ack) begin
        m0_pend_r  <= 1'b0;
      end else begin
        m0_pend_r  <= m0_pend_r;
      end

      if (m1_load_s) begin
        m1_pend_r  <= 1'b1;
        m1_we_r    <= m1_we;
        m1_addr_r  <= m1_addr;
        m1_wdata_r <= m1_wdata;
      end else if (m1_ack) begin
        m1_pend_r  <= 1'b0;
      end else begin
        m1_pend_r  <= m1_pend_r;
      end
    end
  end

  // Access sequencer: IDLE -> ISSUE -> (WAIT) -> DONE, all bus outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      grant_r      <= 1'b0;
      cur_we_r     <= 1'b0;
      cnt_r        <= '0;
`ifdef REG_ARB_RR_EN
      last_grant_r <= 1'b1;
`endif
      reg_addr     <= '0;
      reg_wdata    <= '0;
      reg_wr       <= 1'b0;
      reg_rd       <= 1'b0;
      busy         <= 1'b0;
      m0_ack       <= 1'b0;
      m1_ack       <= 1'b0;
      m0_rdata     <= '0;
      m1_rdata     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (m0_pend_r || m1_pend_r) begin
            grant_r   <= win_s;
            cur_we_r  <= win_s ? m1_we_r : m0_we_r;
            reg_addr  <= win_s ? m1_addr_r : m0_addr_r;
            reg_wdata <= win_s ? m1_wdata_r : m0_wdata_r;
            reg_wr    <= win_s ? m1_we_r : m0_we_r;
            reg_rd    <= win_s ? ~m1_we_r : ~m0_we_r;
            busy      <= 1'b1;
            state_r   <= ISSUE;
          end else begin
            state_r   <= IDLE;
          end
        end

        ISSUE: begin
          reg_wr <= 1'b0;
          reg_rd <= 1'b0;
          if (cur_we_r || (RD_LAT == 0)) begin
            if (!cur_we_r) begin
              if (grant_r) begin
                m1_rdata <= reg_rdata;
              end else begin
                m0_rdata <= reg_rdata;
              end
            end else begin
              cnt_r <= cnt_r;
            end
            m0_ack  <= ~grant_r;
            m1_ack  <= grant_r;
            state_r <= DONE;
          end else begin
            cnt_r   <= CNT_W'(RD_LAT - 1);
            state_r <= WAIT;
          end
        end

        WAIT: begin
          if (cnt_r == '0) begin
            if (grant_r) begin
              m1_rdata <= reg_rdata;
            end else begin
              m0_rdata <= reg_rdata;
            end
            m0_ack  <= ~grant_r;
            m1_ack  <= grant_r;
            state_r <= DONE;
          end else begin
            cnt_r   <= cnt_r - CNT_W'(1);
            state_r <= WAIT;
          end
        end

        DONE: begin
          m0_ack       <= 1'b0;
          m1_ack       <= 1'b0;
          busy         <= 1'b0;
`ifdef REG_ARB_RR_EN
          last_grant_r <= grant_r;
`endif
          state_r      <= IDLE;
        end

        default: begin
          reg_wr  <= 1'b0;
          reg_rd  <= 1'b0;
          m0_ack  <= 1'b0;
          m1_ack  <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter: RD_LAT=1 instance with a register_file model,
// plus an RD_LAT=2 instance with a two-stage delayed read-data model.
module tb_reg_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       m0_req, m0_we, m0_ack, m0_drop;
  logic [7:0] m0_addr, m0_wdata, m0_rdata;
  logic       m1_req, m1_we, m1_ack, m1_drop;
  logic [7:0] m1_addr, m1_wdata, m1_rdata;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_wr, reg_rd, busy;

  logic       b_m0_req, b_m0_we, b_m0_ack, b_m0_drop;
  logic [7:0] b_m0_addr, b_m0_wdata, b_m0_rdata;
  logic       b_m1_req, b_m1_we, b_m1_ack, b_m1_drop;
  logic [7:0] b_m1_addr, b_m1_wdata, b_m1_rdata;
  logic [7:0] b_reg_addr, b_reg_wdata, b_reg_rdata;
  logic       b_reg_wr, b_reg_rd, b_busy;

  reg_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_drop(m0_drop),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_drop(m1_drop),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_rdata(reg_rdata), .busy(busy)
  );

  reg_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(2)) dut_lat2 (
    .clk(clk), .rst_n(rst_n),
    .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
    .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata), .m0_drop(b_m0_drop),
    .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
    .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata), .m1_drop(b_m1_drop),
    .reg_addr(b_reg_addr), .reg_wdata(b_reg_wdata), .reg_wr(b_reg_wr), .reg_rd(b_reg_rd),
    .reg_rdata(b_reg_rdata), .busy(b_busy)
  );

  // register_file model: 0x00 reads 0xA7 after reset, 0x20 drives led_out
  logic [7:0] mem [256];
  logic [7:0] led_out;
  assign led_out = mem[8'h20];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[0]    <= 8'hA7;
      reg_rdata <= 8'h00;
    end else begin
      if (reg_wr) mem[reg_addr] <= reg_wdata;
      if (reg_rd) reg_rdata <= mem[reg_addr];
    end
  end

  // two-stage read model for the RD_LAT=2 instance: 0x05 holds 0xAA
  logic [7:0] b_pipe_a;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_pipe_a    <= 8'h00;
      b_reg_rdata <= 8'h00;
    end else begin
      if (b_reg_rd) b_pipe_a <= (b_reg_addr == 8'h05) ? 8'hAA : 8'h00;
      b_reg_rdata <= b_pipe_a;
    end
  end

  int total = 0;
  int bad = 0;
  int n_wr, n_rd, n_both, n_ack0, n_ack1, n_drop0, n_drop1, n_busy;
  int order[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_wr = 0; n_rd = 0; n_both = 0; n_ack0 = 0; n_ack1 = 0;
    n_drop0 = 0; n_drop1 = 0; n_busy = 0;
    order.delete();
  endtask

  task automatic tick();
    @(negedge clk);
    if (reg_wr) n_wr++;
    if (reg_rd) n_rd++;
    if (reg_wr && reg_rd) n_both++;
    if (busy) n_busy++;
    if (m0_ack) begin n_ack0++; order.push_back(0); end
    if (m1_ack) begin n_ack1++; order.push_back(1); end
    if (m0_drop) n_drop0++;
    if (m1_drop) n_drop1++;
  endtask

  task automatic drive(input int m, input logic we, input logic [7:0] a, input logic [7:0] d);
    if (m == 0) begin m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d; end
    else        begin m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d; end
  endtask

  // ticks until the master's ack is seen; lat = ticks taken, -1 on timeout
  task automatic wait_ack(input int m, input int max, output int lat);
    lat = -1;
    for (int k = 1; k <= max; k++) begin
      tick();
      if ((m == 0 && m0_ack) || (m == 1 && m1_ack)) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  int lat, n0, n1, exp_g;

  initial begin
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 8'h00; m0_wdata = 8'h00;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 8'h00; m1_wdata = 8'h00;
    b_m0_req = 1'b0; b_m0_we = 1'b0; b_m0_addr = 8'h00; b_m0_wdata = 8'h00;
    b_m1_req = 1'b0; b_m1_we = 1'b0; b_m1_addr = 8'h00; b_m1_wdata = 8'h00;
    clear_counts();
    rst_n = 1'b0;
    tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_regwr", reg_wr, 0);
    check_eq("rst_regrd", reg_rd, 0);
    check_eq("rst_m0_rdata", m0_rdata, 0);
    check_eq("rst_m1_rdata", m1_rdata, 0);
    check_eq("rst_acks", {m0_ack, m1_ack, m0_drop, m1_drop}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: m0 write 0x05<-0x55 then read back
    clear_counts();
    drive(0, 1'b1, 8'h05, 8'h55); tick(); m0_req = 1'b0;
    check_eq("t1_busy_n1", busy, 0);
    tick();
    check_eq("t1_regwr_n2", reg_wr, 1);
    check_eq("t1_regrd_n2", reg_rd, 0);
    check_eq("t1_addr_n2", reg_addr, 8'h05);
    check_eq("t1_wdata_n2", reg_wdata, 8'h55);
    check_eq("t1_busy_n2", busy, 1);
    tick();
    check_eq("t1_wack_n3", m0_ack, 1);
    tick();
    drive(0, 1'b0, 8'h05, 8'h00); tick(); m0_req = 1'b0;
    wait_ack(0, 10, lat);
    check_eq("t1_rd_lat", lat, 3);
    tick();
    check_eq("t1_m0_rdata", m0_rdata, 8'h55);
    check_eq("t1_nwr", n_wr, 1);
    check_eq("t1_nrd", n_rd, 1);
    check_eq("t1_nack0", n_ack0, 2);
    check_eq("t1_nack1", n_ack1, 0);

    // 2: same-cycle m0 write 0x20<-0xF0 and m1 read 0x00
    do_reset();
    clear_counts();
    drive(0, 1'b1, 8'h20, 8'hF0); drive(1, 1'b0, 8'h00, 8'h00);
    tick(); m0_req = 1'b0; m1_req = 1'b0;
    wait_ack(1, 20, lat);
    check_eq("t2_m1_lat", lat, 6);
    for (int k = 0; k < 6; k++) tick();
    check_eq("t2_nacks", order.size(), 2);
    if (order.size() >= 2) begin
      check_eq("t2_first", order[0], 0);
      check_eq("t2_second", order[1], 1);
    end
    check_eq("t2_led_out", led_out, 8'hF0);
    check_eq("t2_m1_rdata", m1_rdata, 8'hA7);
    check_eq("t2_m0_rdata", m0_rdata, 8'h00);

    // 3: both masters re-request on every ack, 4 accesses each
    clear_counts();
    drive(0, 1'b1, 8'h40, 8'h01); drive(1, 1'b1, 8'h41, 8'h02);
    n0 = 1; n1 = 1;
    for (int k = 0; k < 80 && (n_ack0 + n_ack1) < 8; k++) begin
      tick();
      m0_req = m0_ack && (n0 < 4);
      if (m0_req) n0++;
      m1_req = m1_ack && (n1 < 4);
      if (m1_req) n1++;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    check_eq("t3_nacks", order.size(), 8);
    for (int i = 0; i < order.size() && i < 8; i++) begin
`ifdef REG_ARB_RR_EN
      exp_g = i % 2;
`else
      exp_g = (i >= 4) ? 1 : 0;
`endif
      check_eq($sformatf("t3_grant%0d", i), order[i], exp_g);
    end
    check_eq("t3_drops", n_drop0 + n_drop1, 0);

    // 4: second m0_req one cycle after the first is dropped
    tick();
    clear_counts();
    drive(0, 1'b0, 8'h00, 8'h00); tick();
    drive(0, 1'b1, 8'h00, 8'h33); tick(); m0_req = 1'b0;
    check_eq("t4_drop_pulse", m0_drop, 1);
    for (int k = 0; k < 12; k++) tick();
    check_eq("t4_ndrop", n_drop0, 1);
    check_eq("t4_nrd", n_rd, 1);
    check_eq("t4_nwr", n_wr, 0);
    check_eq("t4_nack0", n_ack0, 1);
    check_eq("t4_m0_rdata", m0_rdata, 8'hA7);

    // 5: reset during the WAIT cycle of an m1 read
    clear_counts();
    drive(1, 1'b0, 8'h00, 8'h00); tick(); m1_req = 1'b0;
    tick(); tick();
    check_eq("t5_busy_wait", busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("t5_busy_rst", busy, 0);
    check_eq("t5_regrd_rst", reg_rd, 0);
    check_eq("t5_m1_rdata_rst", m1_rdata, 0);
    tick();
    rst_n = 1'b1;
    clear_counts();
    for (int k = 0; k < 8; k++) tick();
    check_eq("t5_nack1", n_ack1, 0);
    check_eq("t5_nbusy", n_busy, 0);
    check_eq("t5_m1_rdata", m1_rdata, 0);

    // 6: RD_LAT=2, m1 read 0x05 -> ack at N+5
    b_m1_req = 1'b1; b_m1_we = 1'b0; b_m1_addr = 8'h05;
    tick(); b_m1_req = 1'b0;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (b_m1_ack) begin lat = k; break; end
    end
    check_eq("t6_lat", lat, 4);
    tick();
    check_eq("t6_m1_rdata", b_m1_rdata, 8'hAA);
    check_eq("t6_other", {b_m0_ack, b_m0_drop, b_m1_drop, b_reg_wr, b_busy}, 0);
    check_eq("t6_m0_rdata", b_m0_rdata, 0);
    check_eq("never_wr_and_rd", n_both, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
